// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// memory ready handshake, a bounded memory wait, and sticky error flags.
module multicycle_control #(
  parameter int OP_W        = 11,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int STRICT      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    instruction,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               reg2loc,
  output logic               br,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ALUsrc,
  output logic               RegWrite,
  output logic               illegal,
  output logic               timeout,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_LDUR, C_STUR, C_CBZ, C_B, C_BAD
  } cls_t;

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic             TO_EN     = (MEM_TIMEOUT > 0);
  localparam logic             STRICT_EN = (STRICT != 0);

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_PASS  = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);

  // Unknown opcodes fall back to R-type when legacy decode is selected.
  function automatic cls_t classify(input logic [OP_W-1:0] op);
    cls_t c;
    if (op == 11'b11111000010)        c = C_LDUR;
    else if (op == 11'b11111000000)   c = C_STUR;
    else if (op[10:3] == 8'b10110100) c = C_CBZ;
    else if (op[10:5] == 6'b000101)   c = C_B;
    else if (op == 11'b10001011000 || op == 11'b11001011000 ||
             op == 11'b10001010000 || op == 11'b10101010000)
      c = C_R;
    else
      c = STRICT_EN ? C_BAD : C_R;
    return c;
  endfunction

  state_t            state_q, state_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;

  cls_t              cls_live;
  cls_t              cls_lat;
  logic              wait_expired;
  logic [CNT_W-1:0]  cnt_inc;

  assign cls_live     = classify(instruction);
  assign cls_lat      = classify(opcode_q);
  assign wait_expired = TO_EN && (cnt_q == CNT_LIMIT) && !mem_ready;
  assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg2loc   = 1'b0;
    br        = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemToReg  = 1'b0;
    ALUOp     = ALU_ADD;
    ALUsrc    = 1'b0;
    RegWrite  = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUOp   = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          cnt_d    = '0;
          state_d  = S_DECODE;
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = S_ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      // The IR is already valid here, so decode it live rather than the latch.
      S_DECODE: begin
        opcode_d = instruction;
        cnt_d    = '0;
        reg2loc  = (cls_live == C_CBZ) || (cls_live == C_STUR);
        if (cls_live == C_BAD) begin
          illegal_d = 1'b1;
          state_d   = S_ERR;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        cnt_d = '0;
        case (cls_lat)
          C_LDUR: begin
            ALUsrc  = 1'b1;
            state_d = S_MEM;
          end
          C_STUR: begin
            ALUsrc  = 1'b1;
            reg2loc = 1'b1;
            state_d = S_MEM;
          end
          C_CBZ: begin
            reg2loc  = 1'b1;
            ALUOp    = ALU_PASS;
            br       = zero;
            pc_write = zero;
            state_d  = S_FETCH;
          end
          C_B: begin
            br       = 1'b1;
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
          default: begin
            ALUOp   = ALU_FUNCT;
            state_d = S_WB;
          end
        endcase
      end

      S_MEM: begin
        MemWrite = (cls_lat == C_STUR);
        MemRead  = (cls_lat != C_STUR);
        if (mem_ready) begin
          cnt_d   = '0;
          state_d = (cls_lat == C_STUR) ? S_FETCH : S_WB;
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = S_ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WB: begin
        RegWrite = 1'b1;
        MemToReg = (cls_lat == C_LDUR);
        cnt_d    = '0;
        state_d  = S_FETCH;
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign state   = state_q;

endmodule
